// File: rtl/bridge_arb_pkg.sv
// Shared types and constants for the three-requester AHB bridge arbiter.
package bridge_arb_pkg;

  localparam int NUM_REQ = 3;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } state_e;

  function automatic logic [1:0] onehot_to_idx(input logic [NUM_REQ-1:0] oh);
    logic [1:0] idx;
    idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (oh[i]) idx = 2'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first requester after last_gnt, with wrap.
module rr_pick
  import bridge_arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [1:0]         last_gnt,
  output logic [NUM_REQ-1:0] winner
);

  logic [1:0] idx;
  logic       found;

  always_comb begin
    winner = '0;
    found  = 1'b0;
    idx    = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = 2'((int'(last_gnt) + k) % NUM_REQ);
      if (!found && req[idx]) begin
        winner[idx] = 1'b1;
        found       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ahb_bridge_arbiter.sv
// Round-robin arbiter feeding single AHB transfers from three requesters to a bridge.
// Optional DATA-phase timeout abort is enabled by defining ARB_TIMEOUT_EN.
module ahb_bridge_arbiter
  import bridge_arb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                 Hclk,
  input  logic                 Hresetn,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [NUM_REQ-1:0]   req_write,
  input  logic [32*NUM_REQ-1:0] req_addr,
  input  logic [32*NUM_REQ-1:0] req_wdata,
  output logic [NUM_REQ-1:0]   gnt,
  output logic [NUM_REQ-1:0]   done,
  output logic                 err,
  output logic [31:0]          rdata,
  output logic                 busy,
  output logic [31:0]          Haddr,
  output logic [31:0]          Hwdata,
  output logic                 Hwrite,
  output logic [1:0]           Htrans,
  output logic                 Hreadyin,
  input  logic                 Hreadyout,
  input  logic [31:0]          Hrdata
);

  state_e             state_q, state_d;
  logic [NUM_REQ-1:0] gnt_q, done_q, winner;
  logic [1:0]         last_gnt_q, win_idx;
  logic [31:0]        addr_q, wdata_q, rdata_q;
  logic               write_q;
  logic               finish, timeout;

  rr_pick u_pick (
    .req      (req),
    .last_gnt (last_gnt_q),
    .winner   (winner)
  );

  assign win_idx = onehot_to_idx(winner);

`ifdef ARB_TIMEOUT_EN
  logic [7:0] tmo_cnt_q;
  logic       err_q;
  assign timeout = (state_q == DATA) && !Hreadyout &&
                   (tmo_cnt_q == 8'(TIMEOUT_CYCLES - 1));
  assign err     = err_q;

  always_ff @(posedge Hclk) begin
    if (!Hresetn) begin
      tmo_cnt_q <= '0;
      err_q     <= 1'b0;
    end else begin
      if (state_q == ADDR)
        tmo_cnt_q <= '0;
      else if (state_q == DATA && !Hreadyout)
        tmo_cnt_q <= tmo_cnt_q + 8'd1;
      if (finish) err_q <= timeout;
    end
  end
`else
  assign timeout = 1'b0;
  assign err     = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    finish  = 1'b0;
    case (state_q)
      IDLE: if (|req) state_d = ADDR;
      ADDR: state_d = DATA;
      DATA: begin
        if (Hreadyout || timeout) begin
          finish  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Hclk) begin
    if (!Hresetn) begin
      state_q    <= IDLE;
      gnt_q      <= '0;
      done_q     <= '0;
      rdata_q    <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      write_q    <= 1'b0;
      last_gnt_q <= 2'd2;
    end else begin
      state_q <= state_d;
      done_q  <= '0;
      // Capture the winner's request so later req_* changes cannot disturb it
      if (state_q == IDLE && |req) begin
        gnt_q   <= winner;
        addr_q  <= req_addr[{win_idx, 5'd0} +: 32];
        wdata_q <= req_wdata[{win_idx, 5'd0} +: 32];
        write_q <= req_write[win_idx];
      end
      if (finish) begin
        done_q     <= gnt_q;
        gnt_q      <= '0;
        last_gnt_q <= onehot_to_idx(gnt_q);
        rdata_q    <= (Hreadyout && !write_q) ? Hrdata : 32'd0;
      end
    end
  end

  assign gnt      = gnt_q;
  assign done     = done_q;
  assign rdata    = rdata_q;
  assign busy     = (state_q != IDLE);
  assign Haddr    = addr_q;
  assign Hwdata   = wdata_q;
  assign Hwrite   = (state_q == ADDR) && write_q;
  assign Htrans   = (state_q == ADDR) ? HTRANS_NONSEQ : HTRANS_IDLE;
  assign Hreadyin = 1'b1;

endmodule

// File: tb/tb_ahb_bridge_arbiter.sv
// Self-checking bench: directed vector table, corner sequences, randomized run vs transaction model.
module tb_ahb_bridge_arbiter;

  localparam int TMO = 16;
`ifdef ARB_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  logic        Hclk = 1'b0;
  logic        Hresetn;
  logic [2:0]  req, req_write;
  logic [95:0] req_addr, req_wdata;
  logic [2:0]  gnt, done;
  logic        err, busy, Hwrite, Hreadyin, Hreadyout;
  logic [31:0] rdata, Haddr, Hwdata, Hrdata;
  logic [1:0]  Htrans;

  int total = 0;
  int passed = 0;

  always #5 Hclk = ~Hclk;

  ahb_bridge_arbiter #(.TIMEOUT_CYCLES(TMO)) dut (
    .Hclk(Hclk), .Hresetn(Hresetn), .req(req), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .gnt(gnt), .done(done),
    .err(err), .rdata(rdata), .busy(busy), .Haddr(Haddr), .Hwdata(Hwdata),
    .Hwrite(Hwrite), .Htrans(Htrans), .Hreadyin(Hreadyin),
    .Hreadyout(Hreadyout), .Hrdata(Hrdata)
  );

  typedef struct {
    bit          rst;
    logic [2:0]  req;
    logic [2:0]  wr;
    logic [2:0]  gnt;
    logic [2:0]  done;
    logic [1:0]  htrans;
    logic        hwrite;
    logic        busy;
    logic [31:0] rdata;
  } vec_t;

  vec_t vt[14];

  // transaction-level reference model state
  bit          m_active;
  int          m_who, m_age, m_last, m_wait;
  logic [31:0] m_addr, m_wdata;
  bit          m_write;
  logic [2:0]  e_done;
  logic [31:0] e_rdata;
  bit          e_err;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", nm, act, exp);
    else passed++;
  endtask

  task automatic tick();
    @(posedge Hclk);
    #1;
  endtask

  task automatic do_reset();
    Hresetn = 1'b0;
    req = '0;
    tick();
    Hresetn = 1'b1;
    m_active = 0; m_last = 2; m_wait = 0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_gnt"}, 32'(gnt), 0);
    chk({tag, "_done"}, 32'(done), 0);
    chk({tag, "_err"}, 32'(err), 0);
    chk({tag, "_rdata"}, rdata, 0);
    chk({tag, "_haddr"}, Haddr, 0);
    chk({tag, "_hwdata"}, Hwdata, 0);
    chk({tag, "_hwrite"}, 32'(Hwrite), 0);
    chk({tag, "_htrans"}, 32'(Htrans), 0);
    chk({tag, "_hreadyin"}, 32'(Hreadyin), 1);
    chk({tag, "_busy"}, 32'(busy), 0);
  endtask

  // Predict the effect of the coming edge from the current inputs.
  task automatic model_step();
    e_done = '0;
    if (!m_active) begin
      if (req != 0) begin
        for (int k = 1; k <= 3; k++) begin
          int c;
          c = (m_last + k) % 3;
          if (req[c]) begin
            m_who = c;
            break;
          end
        end
        m_active = 1; m_age = 0; m_wait = 0;
        m_addr  = req_addr[32*m_who +: 32];
        m_wdata = req_wdata[32*m_who +: 32];
        m_write = req_write[m_who];
      end
    end else if (m_age == 0) begin
      m_age = 1; m_wait = 0;
    end else if (Hreadyout) begin
      e_done = 3'(1 << m_who); e_err = 0;
      e_rdata = m_write ? 32'd0 : Hrdata;
      m_last = m_who; m_active = 0;
    end else if (TMO_EN && m_wait == TMO - 1) begin
      e_done = 3'(1 << m_who); e_err = 1; e_rdata = 0;
      m_last = m_who; m_active = 0;
    end else begin
      m_wait++;
    end
  endtask

  initial begin
    Hresetn = 1'b0; req = '0; req_write = '0; Hreadyout = 1'b1;
    req_addr = '0; req_wdata = '0; Hrdata = '0;
    e_rdata = '0; e_err = 0; m_who = 0; m_age = 0; m_addr = '0; m_wdata = '0; m_write = 0;
    tick();
    tick();
    check_reset_outputs("reset");
    Hresetn = 1'b1;

    // single write from requester 1, then three-way continuous reads
    vt[0]  = '{0, 3'b010, 3'b010, 3'b010, 3'b000, 2'b10, 1, 1, 0};
    vt[1]  = '{0, 3'b000, 3'b000, 3'b010, 3'b000, 2'b00, 0, 1, 0};
    vt[2]  = '{0, 3'b000, 3'b000, 3'b000, 3'b010, 2'b00, 0, 0, 0};
    vt[3]  = '{0, 3'b000, 3'b000, 3'b000, 3'b000, 2'b00, 0, 0, 0};
    vt[4]  = '{1, 3'b111, 3'b000, 3'b001, 3'b000, 2'b10, 0, 1, 0};
    vt[5]  = '{0, 3'b111, 3'b000, 3'b001, 3'b000, 2'b00, 0, 1, 0};
    vt[6]  = '{0, 3'b111, 3'b000, 3'b000, 3'b001, 2'b00, 0, 0, 32'hA5A55A5A};
    vt[7]  = '{0, 3'b111, 3'b000, 3'b010, 3'b000, 2'b10, 0, 1, 0};
    vt[8]  = '{0, 3'b111, 3'b000, 3'b010, 3'b000, 2'b00, 0, 1, 0};
    vt[9]  = '{0, 3'b111, 3'b000, 3'b000, 3'b010, 2'b00, 0, 0, 32'hA5A55A5A};
    vt[10] = '{0, 3'b111, 3'b000, 3'b100, 3'b000, 2'b10, 0, 1, 0};
    vt[11] = '{0, 3'b111, 3'b000, 3'b100, 3'b000, 2'b00, 0, 1, 0};
    vt[12] = '{0, 3'b111, 3'b000, 3'b000, 3'b100, 2'b00, 0, 0, 32'hA5A55A5A};
    vt[13] = '{0, 3'b111, 3'b000, 3'b001, 3'b000, 2'b10, 0, 1, 0};

    req_addr  = {32'h0000_0300, 32'h0000_0010, 32'h0000_0100};
    req_wdata = {32'h3333_3333, 32'hDEAD_BEEF, 32'h1111_1111};
    Hrdata    = 32'hA5A5_5A5A;
    Hreadyout = 1'b1;
    for (int i = 0; i < 14; i++) begin
      if (vt[i].rst) do_reset();
      req = vt[i].req;
      req_write = vt[i].wr;
      tick();
      chk($sformatf("vec%0d_gnt", i), 32'(gnt), 32'(vt[i].gnt));
      chk($sformatf("vec%0d_done", i), 32'(done), 32'(vt[i].done));
      chk($sformatf("vec%0d_htrans", i), 32'(Htrans), 32'(vt[i].htrans));
      chk($sformatf("vec%0d_hwrite", i), 32'(Hwrite), 32'(vt[i].hwrite));
      chk($sformatf("vec%0d_busy", i), 32'(busy), 32'(vt[i].busy));
      chk($sformatf("vec%0d_hreadyin", i), 32'(Hreadyin), 1);
      if (vt[i].done != 0) begin
        chk($sformatf("vec%0d_rdata", i), rdata, vt[i].rdata);
        chk($sformatf("vec%0d_err", i), 32'(err), 0);
      end
      if (i == 0) chk("wr_haddr", Haddr, 32'h10);
      if (i == 1) chk("wr_hwdata", Hwdata, 32'hDEADBEEF);
    end

    // wait states: five not-ready DATA cycles, then ready
    do_reset();
    req = 3'b001; req_write = 3'b000; Hreadyout = 1'b0; Hrdata = 32'h1234_5678;
    tick();
    req = 3'b000;
    tick();
    for (int w = 0; w < 5; w++) begin
      tick();
      chk($sformatf("wait%0d_htrans", w), 32'(Htrans), 0);
      chk($sformatf("wait%0d_gnt", w), 32'(gnt), 32'b001);
      chk($sformatf("wait%0d_done", w), 32'(done), 0);
    end
    Hreadyout = 1'b1;
    tick();
    chk("wait_done", 32'(done), 32'b001);
    chk("wait_rdata", rdata, 32'h1234_5678);

    // stuck bridge: timeout abort when enabled, otherwise waits forever
    do_reset();
    req = 3'b001; Hreadyout = 1'b0;
    tick();
    req = 3'b000;
    tick();
    if (TMO_EN) begin
      for (int w = 0; w < TMO - 1; w++) tick();
      chk("tmo_pre_done", 32'(done), 0);
      chk("tmo_pre_busy", 32'(busy), 1);
      tick();
      chk("tmo_done", 32'(done), 32'b001);
      chk("tmo_err", 32'(err), 1);
      chk("tmo_rdata", rdata, 0);
      chk("tmo_idle", 32'(busy), 0);
    end else begin
      for (int w = 0; w < 40; w++) begin
        tick();
        chk($sformatf("stuck%0d_busy", w), 32'(busy), 1);
        chk($sformatf("stuck%0d_done", w), 32'(done), 0);
      end
    end

    // reset during requester 2's DATA phase, then restart from requester 0
    do_reset();
    req = 3'b100; req_write = 3'b100; Hreadyout = 1'b0;
    tick();
    tick();
    chk("mid_gnt", 32'(gnt), 32'b100);
    Hresetn = 1'b0; Hreadyout = 1'b1;
    tick();
    check_reset_outputs("midrst");
    Hresetn = 1'b1; req = 3'b101;
    tick();
    chk("midrst_first_gnt", 32'(gnt), 32'b001);
    chk("midrst_no_done", 32'(done), 0);

    // randomized traffic against the transaction model
    do_reset();
    for (int cyc = 0; cyc < 500; cyc++) begin
      if ($urandom_range(0, 9) < 3) req = 3'($urandom_range(0, 7));
      req_write = 3'($urandom_range(0, 7));
      req_addr  = {$urandom, $urandom, $urandom};
      req_wdata = {$urandom, $urandom, $urandom};
      Hrdata    = $urandom;
      Hreadyout = ($urandom_range(0, 3) != 0);
      model_step();
      tick();
      chk("rnd_gnt", 32'(gnt), m_active ? 32'(1 << m_who) : 0);
      chk("rnd_done", 32'(done), 32'(e_done));
      chk("rnd_htrans", 32'(Htrans), (m_active && m_age == 0) ? 32'd2 : 32'd0);
      chk("rnd_hwrite", 32'(Hwrite), 32'(m_active && m_age == 0 && m_write));
      chk("rnd_busy", 32'(busy), 32'(m_active));
      chk("rnd_hreadyin", 32'(Hreadyin), 1);
      chk("rnd_onehot", 32'($onehot0(gnt) && $onehot0(done)), 1);
      if (m_active) chk("rnd_haddr", Haddr, m_addr);
      if (m_active && m_age >= 1) chk("rnd_hwdata", Hwdata, m_wdata);
      if (e_done != 0) begin
        chk("rnd_rdata", rdata, e_rdata);
        chk("rnd_err", 32'(err), 32'(e_err));
      end
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
